// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control unit for the datapath
// Moore sequencer: T0-T2 fetch, T3 decodes ir[31:27], T4-T7 execute; stop halts at the next boundary.
module control_sequencer #(
    parameter logic [4:0] INC_PC_CODE = 5'd14,
    parameter logic [4:0] ALU_ADD     = 5'd1,
    parameter logic [4:0] ALU_SUB     = 5'd2,
    parameter logic [4:0] ALU_AND     = 5'd3,
    parameter logic [4:0] ALU_OR      = 5'd4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        run
);

    localparam int EN_ZIN      = 18;
    localparam int EN_YIN      = 19;
    localparam int EN_PCIN     = 20;
    localparam int EN_MDRIN    = 21;
    localparam int EN_IRIN     = 24;
    localparam int EN_MARIN    = 25;
    localparam int EN_OUTPORT  = 26;

    localparam int BS_ZLOW     = 19;
    localparam int BS_PCOUT    = 20;
    localparam int BS_MDROUT   = 21;
    localparam int BS_INPORT   = 22;
    localparam int BS_COUT     = 23;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;

    typedef enum logic [3:0] {
        RST_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT_S
    } state_t;

    state_t state_q, state_d;
    logic   stop_q, stop_d;

    logic [4:0] opcode;
    logic       unused_ir;
    logic       is_ld, is_ldi, is_st, is_rtype, is_itype, is_in, is_out, is_nop;
    logic       is_addr, is_mem, is_short, is_six, is_valid;
    logic [4:0] alu_code;
    logic       run_state, last_step;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];

    assign is_ld    = (opcode == OP_LD);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_st    = (opcode == OP_ST);
    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_itype = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_in    = (opcode == OP_IN);
    assign is_out   = (opcode == OP_OUT);
    assign is_nop   = (opcode == OP_NOP);
    assign is_addr  = is_ld || is_ldi || is_st;
    assign is_mem   = is_ld || is_st;
    assign is_short = is_in || is_out || is_nop;
    assign is_six   = is_ldi || is_rtype || is_itype;
    assign is_valid = is_mem || is_six || is_short;

    // Address arithmetic for ld/ldi/st always adds the offset.
    always_comb begin
        alu_code = ALU_ADD;
        case (opcode)
            OP_SUB:          alu_code = ALU_SUB;
            OP_AND, OP_ANDI: alu_code = ALU_AND;
            OP_OR, OP_ORI:   alu_code = ALU_OR;
            default:         alu_code = ALU_ADD;
        endcase
    end

    assign run_state = (state_q != RST_S) && (state_q != HALT_S);

    always_comb begin
        last_step = 1'b0;
        case (state_q)
            T3:      last_step = is_short;
            T5:      last_step = is_six;
            T7:      last_step = 1'b1;
            default: last_step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RST_S;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stop_d  = run_state ? (stop_q || stop) : 1'b0;
        case (state_q)
            RST_S:   state_d = T0;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = is_valid ? T4 : HALT_S;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T7;
            T7:      state_d = T0;
            HALT_S:  state_d = HALT_S;
            default: state_d = RST_S;
        endcase
        // A stop seen anywhere in the instruction turns its boundary into a halt.
        if (last_step) begin
            state_d = (stop_q || stop) ? HALT_S : T0;
        end
        if (last_step || state_d == HALT_S) begin
            stop_d = 1'b0;
        end
    end

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        run             = run_state;
        case (state_q)
            T0: begin
                busSelect[BS_PCOUT] = 1'b1;
                enable[EN_MARIN]    = 1'b1;
                enable[EN_ZIN]      = 1'b1;
                Control_Signals     = INC_PC_CODE;
            end
            T1: begin
                busSelect[BS_ZLOW] = 1'b1;
                enable[EN_PCIN]    = 1'b1;
                enable[EN_MDRIN]   = 1'b1;
                MD_Read            = 1'b1;
                ReadRAM            = 1'b1;
            end
            T2: begin
                busSelect[BS_MDROUT] = 1'b1;
                enable[EN_IRIN]      = 1'b1;
            end
            T3: begin
                if (is_addr) begin
                    Grb            = 1'b1;
                    BAout          = 1'b1;
                    enable[EN_YIN] = 1'b1;
                end else if (is_rtype || is_itype) begin
                    Grb            = 1'b1;
                    Rout           = 1'b1;
                    enable[EN_YIN] = 1'b1;
                end else if (is_in) begin
                    busSelect[BS_INPORT] = 1'b1;
                    Gra                  = 1'b1;
                    Rin                  = 1'b1;
                end else if (is_out) begin
                    Gra                 = 1'b1;
                    Rout                = 1'b1;
                    enable[EN_OUTPORT]  = 1'b1;
                end
            end
            T4: begin
                enable[EN_ZIN]  = 1'b1;
                Control_Signals = alu_code;
                if (is_rtype) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    busSelect[BS_COUT] = 1'b1;
                end
            end
            T5: begin
                busSelect[BS_ZLOW] = 1'b1;
                if (is_mem) begin
                    enable[EN_MARIN] = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            T6: begin
                enable[EN_MDRIN] = 1'b1;
                if (is_ld) begin
                    MD_Read = 1'b1;
                    ReadRAM = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    busSelect[BS_MDROUT] = 1'b1;
                    Gra                  = 1'b1;
                    Rin                  = 1'b1;
                end else begin
                    WriteRAM = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against an instruction-level model
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        stop;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [4:0]  Control_Signals;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM, run;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .enable(enable), .busSelect(busSelect), .Control_Signals(Control_Signals),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .run(run)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] E_Z   = 32'h0004_0000;
    localparam logic [31:0] E_Y   = 32'h0008_0000;
    localparam logic [31:0] E_PC  = 32'h0010_0000;
    localparam logic [31:0] E_MDR = 32'h0020_0000;
    localparam logic [31:0] E_IR  = 32'h0100_0000;
    localparam logic [31:0] E_MAR = 32'h0200_0000;
    localparam logic [31:0] E_OUT = 32'h0400_0000;
    localparam logic [31:0] B_ZLO = 32'h0008_0000;
    localparam logic [31:0] B_PC  = 32'h0010_0000;
    localparam logic [31:0] B_MDR = 32'h0020_0000;
    localparam logic [31:0] B_IN  = 32'h0040_0000;
    localparam logic [31:0] B_C   = 32'h0080_0000;
    // flag order: Gra Grb Grc Rin Rout BAout MD_Read ReadRAM WriteRAM
    localparam logic [8:0] F_GRA = 9'h100, F_GRB = 9'h080, F_GRC = 9'h040, F_RIN = 9'h020;
    localparam logic [8:0] F_ROUT = 9'h010, F_BA = 9'h008, F_MDRD = 9'h004, F_RD = 9'h002, F_WR = 9'h001;

    localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;

    int checks = 0;
    int errors = 0;
    int m_mode, m_step;
    bit m_stop;
    bit watch_wr = 1'b0, wr_seen = 1'b0;
    logic [31:0] next_ir;

    function automatic logic [78:0] mk(input logic [31:0] en, input logic [31:0] bs,
                                       input logic [4:0] cs, input logic [8:0] fl);
        return {en, bs, cs, fl, 1'b1};
    endfunction

    function automatic int ins_len(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00010:                           return 8;
            5'b00001, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01100, 5'b01101, 5'b01110:       return 6;
            5'b10110, 5'b10111, 5'b11010:                 return 4;
            default:                                      return 0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00100:           return 5'd2;
            5'b00101, 5'b01101: return 5'd3;
            5'b00110, 5'b01110: return 5'd4;
            default:            return 5'd1;
        endcase
    endfunction

    // Micro-step table: what one instruction asserts in its step-th cycle.
    function automatic logic [78:0] exp_word(input logic [4:0] op, input int step);
        if (step == 0) return mk(E_MAR | E_Z, B_PC, 5'd14, 9'h0);
        if (step == 1) return mk(E_PC | E_MDR, B_ZLO, 5'd0, F_MDRD | F_RD);
        if (step == 2) return mk(E_IR, B_MDR, 5'd0, 9'h0);
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                if (step == 3) return mk(E_Y, 32'h0, 5'd0, F_GRB | F_BA);
                if (step == 4) return mk(E_Z, B_C, 5'd1, 9'h0);
                if (step == 5) return (op == 5'b00001) ? mk(32'h0, B_ZLO, 5'd0, F_GRA | F_RIN)
                                                       : mk(E_MAR, B_ZLO, 5'd0, 9'h0);
                if (step == 6) return (op == 5'b00000) ? mk(E_MDR, 32'h0, 5'd0, F_MDRD | F_RD)
                                                       : mk(E_MDR, 32'h0, 5'd0, F_GRA | F_ROUT);
                return (op == 5'b00000) ? mk(32'h0, B_MDR, 5'd0, F_GRA | F_RIN)
                                        : mk(32'h0, 32'h0, 5'd0, F_WR);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                if (step == 3) return mk(E_Y, 32'h0, 5'd0, F_GRB | F_ROUT);
                if (step == 4) return mk(E_Z, 32'h0, alu_of(op), F_GRC | F_ROUT);
                return mk(32'h0, B_ZLO, 5'd0, F_GRA | F_RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                if (step == 3) return mk(E_Y, 32'h0, 5'd0, F_GRB | F_ROUT);
                if (step == 4) return mk(E_Z, B_C, alu_of(op), 9'h0);
                return mk(32'h0, B_ZLO, 5'd0, F_GRA | F_RIN);
            end
            5'b10110: return mk(32'h0, B_IN, 5'd0, F_GRA | F_RIN);
            5'b10111: return mk(E_OUT, 32'h0, 5'd0, F_GRA | F_ROUT);
            default:  return mk(32'h0, 32'h0, 5'd0, 9'h0);
        endcase
    endfunction

    // Instruction-level model: mode, step within current instruction, sticky stop.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_mode <= M_RST;
            m_step <= 0;
            m_stop <= 1'b0;
        end else if (m_mode == M_RST) begin
            m_mode <= M_RUN;
            m_step <= 0;
            m_stop <= 1'b0;
        end else if (m_mode == M_RUN) begin
            if (m_step >= 3 && ins_len(ir[31:27]) == 0) begin
                m_mode <= M_HALT;
            end else if (m_step == ins_len(ir[31:27]) - 1) begin
                if (m_stop || stop) m_mode <= M_HALT;
                m_step <= 0;
                m_stop <= 1'b0;
            end else begin
                m_step <= m_step + 1;
                m_stop <= m_stop || stop;
            end
        end
    end

    always @(negedge clk) begin
        logic [78:0] got, want;
        got  = {enable, busSelect, Control_Signals, Gra, Grb, Grc, Rin, Rout, BAout,
                MD_Read, ReadRAM, WriteRAM, run};
        want = (m_mode == M_RUN) ? exp_word(ir[31:27], m_step) : 79'h0;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle_compare t=%0t mode=%0d step=%0d op=%b got=%h want=%h",
                     $time, m_mode, m_step, ir[31:27], got, want);
        end
        if (watch_wr && WriteRAM) wr_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_mode == M_RUN && m_step == 2) ir = next_ir;
    endtask

    function automatic logic [31:0] rand_instr();
        int r;
        logic [4:0] op;
        r = $urandom_range(0, 17);
        case (r)
            0:  op = 5'b00000;  1:  op = 5'b00001;  2:  op = 5'b00010;
            3:  op = 5'b00011;  4:  op = 5'b00100;  5:  op = 5'b00101;
            6:  op = 5'b00110;  7:  op = 5'b01100;  8:  op = 5'b01101;
            9:  op = 5'b01110;  10: op = 5'b10110;  11: op = 5'b10111;
            12: op = 5'b11010;  13: op = 5'b11011;
            default: op = 5'($urandom_range(0, 31));
        endcase
        return {op, 27'($urandom)};
    endfunction

    initial begin
        int halt_cnt;
        clr = 1'b0;
        stop = 1'b0;
        ir = 32'hD000_0000;
        next_ir = 32'h0908_0003;
        tick();
        tick();
        chk("rst_enable", enable, 32'h0);
        chk("rst_bus", busSelect, 32'h0);
        chk("rst_run", {31'h0, run}, 32'h0);

        clr = 1'b1;
        tick();
        chk("t0_enable", enable, 32'h0204_0000);
        chk("t0_bus", busSelect, 32'h0010_0000);
        chk("t0_cs", {27'h0, Control_Signals}, 32'd14);

        repeat (3) tick();
        chk("ldi_t3_enable", enable, 32'h0008_0000);
        chk("ldi_t3_grb_ba", {30'h0, Grb, BAout}, 32'h3);
        tick();
        chk("ldi_t4_bus", busSelect, 32'h0080_0000);
        chk("ldi_t4_cs", {27'h0, Control_Signals}, 32'd1);
        chk("ldi_t4_enable", enable, 32'h0004_0000);
        tick();
        chk("ldi_t5_bus", busSelect, 32'h0008_0000);
        chk("ldi_t5_gra_rin", {30'h0, Gra, Rin}, 32'h3);
        next_ir = {5'b00010, 27'h0123456};
        tick();
        chk("ldi_6cyc_t0", enable, 32'h0204_0000);

        repeat (6) tick();
        chk("st_t6_enable", enable, 32'h0020_0000);
        chk("st_t6_flags", {29'h0, Gra, Rout, MD_Read}, 32'h6);
        tick();
        chk("st_t7_wr", {31'h0, WriteRAM}, 32'h1);
        chk("st_t7_other", enable | busSelect | {27'h0, Control_Signals}, 32'h0);
        next_ir = {5'b00100, 27'h0};
        tick();
        chk("st_8cyc_t0", busSelect, 32'h0010_0000);

        repeat (4) tick();
        chk("sub_t4_cs", {27'h0, Control_Signals}, 32'd2);
        chk("sub_t4_grc_rout", {30'h0, Grc, Rout}, 32'h3);
        chk("sub_t4_enable", enable, 32'h0004_0000);
        next_ir = {5'b01110, 27'h0000055};
        repeat (2) tick();
        repeat (4) tick();
        chk("ori_t4_bus", busSelect, 32'h0080_0000);
        chk("ori_t4_cs", {27'h0, Control_Signals}, 32'd4);
        next_ir = {5'b00000, 27'h0400010};
        repeat (2) tick();

        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        chk("ld_t7_bus", busSelect, 32'h0020_0000);
        chk("ld_t7_gra_rin", {30'h0, Gra, Rin}, 32'h3);
        tick();
        chk("halt_run", {31'h0, run}, 32'h0);
        stop = 1'b1;
        repeat (20) begin
            tick();
            chk("halt_hold", {31'h0, run} | enable | busSelect, 32'h0);
        end
        stop = 1'b0;
        clr = 1'b0;
        tick();
        next_ir = {5'b00010, 27'h0000777};
        clr = 1'b1;
        tick();
        chk("halt_restart_t0", enable, 32'h0204_0000);

        repeat (6) tick();
        watch_wr = 1'b1;
        clr = 1'b0;
        #1;
        chk("abort_outputs", enable | busSelect | {31'h0, run}, 32'h0);
        tick();
        clr = 1'b1;
        tick();
        watch_wr = 1'b0;
        chk("abort_no_write", {31'h0, wr_seen}, 32'h0);
        chk("abort_restart_t0", enable, 32'h0204_0000);

        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            stop = ($urandom_range(0, 39) == 0);
            next_ir = rand_instr();
            if (m_mode == M_HALT) begin
                halt_cnt++;
                if (halt_cnt > 3) begin
                    clr = 1'b0;
                    halt_cnt = 0;
                end
            end else if (!clr) begin
                clr = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                clr = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
